// File: rtl/unidade_pc.sv
// Program-counter sequencer for the control unit: selects the next PC from flow-control decode
// and enforces the OS preemption quantum by forcing a jump to the OS vector.
//
// state  | meaning
// EXEC   | fetching one instruction per cycle, quantum counting
// ESPERA | halted on status, waits for a new confirma rising edge
module unidade_pc #(
    parameter int PC_W      = 10,
    parameter int QUANTUM   = 64,
    parameter int OS_VECTOR = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            desvio,
    input  logic            jump_reg,
    input  logic            branch,
    input  logic            branch_tipo,
    input  logic            ula_zero,
    input  logic            status,
    input  logic            confirma,
    input  logic            muda_processo,
    input  logic [PC_W-1:0] imediato,
    input  logic [PC_W-1:0] reg_alvo,
    input  logic [PC_W-1:0] ctx_pc,
    input  logic            preempt_en,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_link,
    output logic [PC_W-1:0] pc_salvo,
    output logic            preempcao,
    output logic            parado
);

    localparam int CNT_W = $clog2(QUANTUM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM - 1);
    localparam logic [PC_W-1:0]  OS_PC    = PC_W'(OS_VECTOR);

    typedef enum logic {
        EXEC   = 1'b0,
        ESPERA = 1'b1
    } state_t;

    state_t            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   salvo_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              conf_q;
    logic              pre_q;
    logic              parado_q;

    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   pc_nominal_d;
    logic              branch_ok;
    logic              expira;
    logic              conf_rise;

    assign pc_inc    = pc_q + PC_W'(1);
    assign branch_ok = branch & (branch_tipo ? ~ula_zero : ula_zero);
    assign expira    = preempt_en & (cnt_q == CNT_LAST);
    assign conf_rise = confirma & ~conf_q;

    // Where the program would have gone had no preemption happened; this is the resume PC.
    always_comb begin
        pc_nominal_d = pc_inc;
        if (desvio && jump_reg) begin
            pc_nominal_d = reg_alvo;
        end else if (desvio) begin
            pc_nominal_d = imediato;
        end else if (branch_ok) begin
            pc_nominal_d = imediato;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= EXEC;
            pc_q     <= '0;
            salvo_q  <= '0;
            cnt_q    <= '0;
            conf_q   <= 1'b0;
            pre_q    <= 1'b0;
            parado_q <= 1'b0;
        end else begin
            conf_q <= confirma;
            pre_q  <= 1'b0;
            case (state_q)
                EXEC: begin
                    if (status) begin
                        state_q  <= ESPERA;
                        parado_q <= 1'b1;
                        if (!preempt_en) cnt_q <= '0;
                    end else if (muda_processo) begin
                        pc_q  <= ctx_pc;
                        cnt_q <= '0;
                    end else if (expira) begin
                        salvo_q <= pc_nominal_d;
                        pc_q    <= OS_PC;
                        pre_q   <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        pc_q  <= pc_nominal_d;
                        cnt_q <= preempt_en ? cnt_q + CNT_W'(1) : '0;
                    end
                end
                ESPERA: begin
                    if (!preempt_en) cnt_q <= '0;
                    if (conf_rise) begin
                        pc_q     <= pc_inc;
                        state_q  <= EXEC;
                        parado_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= EXEC;
                    parado_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc        = pc_q;
    assign pc_link   = pc_inc;
    assign pc_salvo  = salvo_q;
    assign preempcao = pre_q;
    assign parado    = parado_q;

endmodule

// File: tb/tb_unidade_pc.sv
// Directed bench for unidade_pc: expected PC/flags are queued as each step is driven and
// compared after the following rising edge.
module tb_unidade_pc;

    localparam int PC_W      = 10;
    localparam int QUANTUM   = 4;
    localparam int OS_VECTOR = 16;

    logic            clock = 1'b0;
    logic            reset;
    logic            desvio, jump_reg, branch, branch_tipo, ula_zero;
    logic            status, confirma, muda_processo, preempt_en;
    logic [PC_W-1:0] imediato, reg_alvo, ctx_pc;
    logic [PC_W-1:0] pc, pc_link, pc_salvo;
    logic            preempcao, parado;

    always #5 clock = ~clock;

    unidade_pc #(
        .PC_W(PC_W), .QUANTUM(QUANTUM), .OS_VECTOR(OS_VECTOR)
    ) dut (
        .clock(clock), .reset(reset),
        .desvio(desvio), .jump_reg(jump_reg), .branch(branch),
        .branch_tipo(branch_tipo), .ula_zero(ula_zero),
        .status(status), .confirma(confirma), .muda_processo(muda_processo),
        .imediato(imediato), .reg_alvo(reg_alvo), .ctx_pc(ctx_pc),
        .preempt_en(preempt_en),
        .pc(pc), .pc_link(pc_link), .pc_salvo(pc_salvo),
        .preempcao(preempcao), .parado(parado)
    );

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            parado;
        logic            pre;
        logic [PC_W-1:0] salvo;
    } exp_t;

    exp_t            sb[$];
    int              n_checks = 0;
    int              n_pass   = 0;
    logic [PC_W-1:0] m_salvo;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic expect_out(input logic [PC_W-1:0] p, input logic pd, input logic pr);
        sb.push_back('{p, pd, pr, m_salvo});
    endtask

    task automatic compare_out(input string tag);
        exp_t            e;
        logic [PC_W-1:0] lk;
        if (sb.size() == 0) begin
            n_checks++;
            $error("FAIL %s: scoreboard empty, observed pc %0d expected an entry", tag, pc);
            return;
        end
        e  = sb.pop_front();
        lk = e.pc + PC_W'(1);
        check({tag, " pc"},        32'(pc),        32'(e.pc));
        check({tag, " pc_link"},   32'(pc_link),   32'(lk));
        check({tag, " parado"},    32'(parado),    32'(e.parado));
        check({tag, " preempcao"}, 32'(preempcao), 32'(e.pre));
        check({tag, " pc_salvo"},  32'(pc_salvo),  32'(e.salvo));
    endtask

    task automatic step(input string tag, input logic [PC_W-1:0] p, input logic pd, input logic pr);
        expect_out(p, pd, pr);
        @(posedge clock);
        #1;
        compare_out(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        desvio = 1'b0; jump_reg = 1'b0; branch = 1'b0; branch_tipo = 1'b0; ula_zero = 1'b0;
        status = 1'b0; confirma = 1'b0; muda_processo = 1'b0; preempt_en = 1'b0;
        imediato = '0; reg_alvo = '0; ctx_pc = '0;
        m_salvo = '0;

        #2;
        expect_out(0, 0, 0);
        compare_out("reset");
        #10 reset = 1'b1;

        for (int i = 1; i <= 5; i++) step("idle", PC_W'(i), 0, 0);

        desvio = 1'b1; imediato = 10'd40;        step("jump", 40, 0, 0);
        jump_reg = 1'b1; reg_alvo = 10'd7;       step("jump_reg", 7, 0, 0);
        desvio = 1'b0; jump_reg = 1'b0;
        branch = 1'b1; branch_tipo = 1'b1; ula_zero = 1'b0; imediato = 10'd20;
        step("bne_taken", 20, 0, 0);
        branch_tipo = 1'b0;                      step("beq_not_taken", 21, 0, 0);
        ula_zero = 1'b1; imediato = 10'd30;      step("beq_taken", 30, 0, 0);
        branch_tipo = 1'b1;                      step("bne_not_taken", 31, 0, 0);
        branch = 1'b0; ula_zero = 1'b0; jump_reg = 1'b1;
        step("jump_reg_alone", 32, 0, 0);
        jump_reg = 1'b0;

        desvio = 1'b1; imediato = 10'd9; confirma = 1'b1;
        step("to_9", 9, 0, 0);
        desvio = 1'b0; status = 1'b1;            step("halt", 9, 1, 0);
        for (int i = 0; i < 10; i++) step("halt_hold", 9, 1, 0);
        status = 1'b0; confirma = 1'b0;          step("confirm_low", 9, 1, 0);
        confirma = 1'b1;                         step("confirm_rise", 10, 0, 0);
        confirma = 1'b0;

        desvio = 1'b1; imediato = 10'd1023;      step("to_max", 1023, 0, 0);
        desvio = 1'b0;                           step("wrap", 0, 0, 0);

        preempt_en = 1'b1;
        step("q_1", 1, 0, 0);
        step("q_2", 2, 0, 0);
        step("q_3", 3, 0, 0);
        m_salvo = 10'd4;                         step("expire", 16, 0, 1);
        step("after_expire", 17, 0, 0);
        step("q_18", 18, 0, 0);
        step("q_19", 19, 0, 0);
        desvio = 1'b1; imediato = 10'd50; m_salvo = 10'd50;
        step("expire_with_jump", 16, 0, 1);
        desvio = 1'b0;

        step("q_17", 17, 0, 0);
        step("q_18b", 18, 0, 0);
        muda_processo = 1'b1; ctx_pc = 10'd100;  step("switch", 100, 0, 0);
        muda_processo = 1'b0;
        step("s_101", 101, 0, 0);
        step("s_102", 102, 0, 0);
        step("s_103", 103, 0, 0);
        m_salvo = 10'd104;                       step("expire_after_switch", 16, 0, 1);

        step("c_17", 17, 0, 0);
        step("c_18", 18, 0, 0);
        preempt_en = 1'b0;                       step("clear_19", 19, 0, 0);
        preempt_en = 1'b1;
        step("c_20", 20, 0, 0);
        step("c_21", 21, 0, 0);
        step("c_22", 22, 0, 0);
        m_salvo = 10'd23;                        step("expire_after_clear", 16, 0, 1);

        preempt_en = 1'b0; status = 1'b1;        step("halt_again", 16, 1, 0);
        status = 1'b0;
        #3 reset = 1'b0;
        #1;
        m_salvo = '0;
        expect_out(0, 0, 0);
        compare_out("async_reset");
        #2 reset = 1'b1;
        step("post_reset", 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
